// File: rtl/vip_ctrl_packet_inserter.sv
// VIP packet framer: wraps each pixel stream in a type-0 video packet and
// inserts a type-0xF control packet ahead of the next frame when requested.
module vip_ctrl_packet_inserter #(
    parameter int BITS_PER_SYMBOL  = 8,
    parameter int SYMBOLS_PER_BEAT = 3,
    parameter bit ALWAYS_SEND      = 1'b0,
    localparam int DW = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din_data,
    input  logic          din_eop,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout_data,
    output logic          dout_sop,
    output logic          dout_eop,
    input  logic [15:0]   width,
    input  logic [15:0]   height,
    input  logic [3:0]    interlaced,
    input  logic          ctrl_send,
    output logic          ctrl_busy
);

    localparam int CTRL_BEATS = (9 + SYMBOLS_PER_BEAT - 1) / SYMBOLS_PER_BEAT;
    localparam logic [3:0] LAST_BEAT = 4'(CTRL_BEATS - 1);
    localparam logic [DW-1:0] TYPE_CTRL = DW'(4'hF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CTRL_HDR,
        S_CTRL_DATA,
        S_VID_HDR,
        S_VID_DATA
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    beat, beat_nxt;
    logic          pending, pending_nxt;
    logic [15:0]   sh_w, sh_w_nxt, sh_h, sh_h_nxt;
    logic [3:0]    sh_i, sh_i_nxt;
    logic [15:0]   tx_w, tx_w_nxt, tx_h, tx_h_nxt;
    logic [3:0]    tx_i, tx_i_nxt;
    logic          dv_nxt, ds_nxt, de_nxt, busy_nxt;
    logic [DW-1:0] dd_nxt, ctrl_data;
    logic [35:0]   syms;
    logic          ld;

    assign ld = ~dout_valid | dout_ready;

    // Symbol 0 (width MS nibble) occupies the lowest nibble.
    assign syms = {tx_i,
                   tx_h[3:0], tx_h[7:4], tx_h[11:8], tx_h[15:12],
                   tx_w[3:0], tx_w[7:4], tx_w[11:8], tx_w[15:12]};

    always_comb begin
        ctrl_data = '0;
        for (int k = 0; k < SYMBOLS_PER_BEAT; k++) begin
            for (int j = 0; j < 9; j++) begin
                if (int'(beat) * SYMBOLS_PER_BEAT + k == j)
                    ctrl_data[k*BITS_PER_SYMBOL +: 4] = syms[j*4 +: 4];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        beat_nxt    = beat;
        pending_nxt = pending;
        sh_w_nxt    = sh_w;
        sh_h_nxt    = sh_h;
        sh_i_nxt    = sh_i;
        tx_w_nxt    = tx_w;
        tx_h_nxt    = tx_h;
        tx_i_nxt    = tx_i;
        dv_nxt      = dout_valid;
        dd_nxt      = dout_data;
        ds_nxt      = dout_sop;
        de_nxt      = dout_eop;
        din_ready   = 1'b0;

        if (ctrl_send) begin
            pending_nxt = 1'b1;
            sh_w_nxt    = width;
            sh_h_nxt    = height;
            sh_i_nxt    = interlaced;
        end

        if (ld) begin
            dv_nxt = 1'b0;
            ds_nxt = 1'b0;
            de_nxt = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                if (din_valid)
                    state_nxt = (pending | ALWAYS_SEND | ctrl_send) ?
                                S_CTRL_HDR : S_VID_HDR;
            end
            S_CTRL_HDR: begin
                if (ld) begin
                    dv_nxt      = 1'b1;
                    dd_nxt      = TYPE_CTRL;
                    ds_nxt      = 1'b1;
                    tx_w_nxt    = ctrl_send ? width      : sh_w;
                    tx_h_nxt    = ctrl_send ? height     : sh_h;
                    tx_i_nxt    = ctrl_send ? interlaced : sh_i;
                    pending_nxt = 1'b0;
                    beat_nxt    = '0;
                    state_nxt   = S_CTRL_DATA;
                end
            end
            S_CTRL_DATA: begin
                if (ld) begin
                    dv_nxt = 1'b1;
                    dd_nxt = ctrl_data;
                    de_nxt = (beat == LAST_BEAT);
                    if (beat == LAST_BEAT)
                        state_nxt = S_VID_HDR;
                    else
                        beat_nxt = beat + 4'd1;
                end
            end
            S_VID_HDR: begin
                if (ld) begin
                    dv_nxt    = 1'b1;
                    dd_nxt    = '0;
                    ds_nxt    = 1'b1;
                    state_nxt = S_VID_DATA;
                end
            end
            S_VID_DATA: begin
                din_ready = ld;
                if (ld && din_valid) begin
                    dv_nxt = 1'b1;
                    dd_nxt = din_data;
                    de_nxt = din_eop;
                    if (din_eop)
                        state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt = pending_nxt | ctrl_send |
                   (state_nxt == S_CTRL_HDR) | (state_nxt == S_CTRL_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            beat       <= '0;
            pending    <= 1'b0;
            sh_w       <= '0;
            sh_h       <= '0;
            sh_i       <= '0;
            tx_w       <= '0;
            tx_h       <= '0;
            tx_i       <= '0;
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            ctrl_busy  <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat       <= beat_nxt;
            pending    <= pending_nxt;
            sh_w       <= sh_w_nxt;
            sh_h       <= sh_h_nxt;
            sh_i       <= sh_i_nxt;
            tx_w       <= tx_w_nxt;
            tx_h       <= tx_h_nxt;
            tx_i       <= tx_i_nxt;
            dout_valid <= dv_nxt;
            dout_data  <= dd_nxt;
            dout_sop   <= ds_nxt;
            dout_eop   <= de_nxt;
            ctrl_busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_vip_ctrl_packet_inserter.sv
// Bench for vip_ctrl_packet_inserter: three instances (S=3, S=1, ALWAYS_SEND)
// share one sink; expected beats queue up as stimulus is driven.
module tb_vip_ctrl_packet_inserter;

    typedef struct packed {
        logic [23:0] d;
        logic        s;
        logic        e;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  vin;
    logic [2:0]  csend;
    logic [23:0] din_data;
    logic        din_eop;
    logic        dout_ready;
    logic [15:0] width, height;
    logic [3:0]  interlaced;

    wire [2:0]  rdy, odv, osop, oeop, busy;
    wire [23:0] d0, d2;
    wire [7:0]  d1;
    logic [2:0][23:0] odata;
    assign odata[0] = d0;
    assign odata[1] = {16'h0, d1};
    assign odata[2] = d2;

    vip_ctrl_packet_inserter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3),
                               .ALWAYS_SEND(1'b0)) dut (
        .clk(clk), .rst(rst),
        .din_valid(vin[0]), .din_ready(rdy[0]), .din_data(din_data),
        .din_eop(din_eop), .dout_valid(odv[0]), .dout_ready(dout_ready),
        .dout_data(d0), .dout_sop(osop[0]), .dout_eop(oeop[0]),
        .width(width), .height(height), .interlaced(interlaced),
        .ctrl_send(csend[0]), .ctrl_busy(busy[0]));

    vip_ctrl_packet_inserter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1),
                               .ALWAYS_SEND(1'b0)) dut_s1 (
        .clk(clk), .rst(rst),
        .din_valid(vin[1]), .din_ready(rdy[1]), .din_data(din_data[7:0]),
        .din_eop(din_eop), .dout_valid(odv[1]), .dout_ready(dout_ready),
        .dout_data(d1), .dout_sop(osop[1]), .dout_eop(oeop[1]),
        .width(width), .height(height), .interlaced(interlaced),
        .ctrl_send(csend[1]), .ctrl_busy(busy[1]));

    vip_ctrl_packet_inserter #(.BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3),
                               .ALWAYS_SEND(1'b1)) dut_as (
        .clk(clk), .rst(rst),
        .din_valid(vin[2]), .din_ready(rdy[2]), .din_data(din_data),
        .din_eop(din_eop), .dout_valid(odv[2]), .dout_ready(dout_ready),
        .dout_data(d2), .dout_sop(osop[2]), .dout_eop(oeop[2]),
        .width(width), .height(height), .interlaced(interlaced),
        .ctrl_send(csend[2]), .ctrl_busy(busy[2]));

    int    vectors = 0;
    int    miscompares = 0;
    int    xfers = 0;
    beat_t exp_q[$];
    beat_t hold_b[3];
    logic [2:0] stall = '0;
    logic  done;

    // Sink monitor: inputs change just after posedge, so the negedge view
    // is exactly what the next posedge will see.
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            stall = '0;
        end else begin
            for (int u = 0; u < 3; u++) begin
                if (stall[u]) begin
                    vectors++;
                    if (!odv[u] || odata[u] !== hold_b[u].d ||
                        osop[u] !== hold_b[u].s || oeop[u] !== hold_b[u].e) begin
                        miscompares++;
                        $display("FAIL stall_hold u%0d: got v=%b d=%h s=%b e=%b, required d=%h s=%b e=%b",
                                 u, odv[u], odata[u], osop[u], oeop[u],
                                 hold_b[u].d, hold_b[u].s, hold_b[u].e);
                    end
                end
                stall[u]  = odv[u] && !dout_ready;
                hold_b[u] = {odata[u], osop[u], oeop[u]};
                if (odv[u] && dout_ready) begin
                    xfers++;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_beat u%0d: got d=%h s=%b e=%b, required no beat",
                                 u, odata[u], osop[u], oeop[u]);
                    end else begin
                        e = exp_q.pop_front();
                        if (odata[u] !== e.d || osop[u] !== e.s || oeop[u] !== e.e) begin
                            miscompares++;
                            $display("FAIL beat u%0d: got d=%h s=%b e=%b, required d=%h s=%b e=%b",
                                     u, odata[u], osop[u], oeop[u], e.d, e.s, e.e);
                        end
                    end
                end
            end
        end
    end

    task automatic push(logic [23:0] d, logic s, logic e);
        exp_q.push_back({d, s, e});
    endtask

    function automatic logic [23:0] ctrl_beat(logic [15:0] w, logic [15:0] h,
                                              logic [3:0] il, int s, int b);
        logic [3:0]  sym [9];
        logic [23:0] r;
        sym = '{w[15:12], w[11:8], w[7:4], w[3:0],
                h[15:12], h[11:8], h[7:4], h[3:0], il};
        r = '0;
        for (int k = 0; k < s; k++)
            if (b * s + k < 9) r[k*8 +: 4] = sym[b*s+k];
        return r;
    endfunction

    task automatic push_ctrl(logic [15:0] w, logic [15:0] h, logic [3:0] il, int s);
        int nb;
        nb = (9 + s - 1) / s;
        push(24'h00000F, 1'b1, 1'b0);
        for (int b = 0; b < nb; b++)
            push(ctrl_beat(w, h, il, s, b), 1'b0, b == nb - 1);
    endtask

    task automatic pulse_ctrl(int u, logic [15:0] w, logic [15:0] h, logic [3:0] il);
        width      = w;
        height     = h;
        interlaced = il;
        csend[u]   = 1'b1;
        @(posedge clk);
        #1;
        csend[u]   = 1'b0;
        vectors++;
        if (busy[u] !== 1'b1) begin
            miscompares++;
            $display("FAIL ctrl_busy_set u%0d: got %b, required 1", u, busy[u]);
        end
    endtask

    task automatic drive_pixel(int u, logic [23:0] d, logic e);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        vin[u]   = 1'b1;
        din_data = d;
        din_eop  = e;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = rdy[u];
            @(posedge clk);
            #1;
            t++;
        end
        vin[u] = 1'b0;
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL pixel_accept_timeout u%0d: got no din_ready, required accept", u);
        end
    endtask

    task automatic send_frame(int u, int n, bit gaps);
        logic [23:0] d;
        push(24'h0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            d = 24'($urandom);
            if (u == 1) d = d & 24'h0000FF;
            push(d, 1'b0, i == n - 1);
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            drive_pixel(u, d, i == n - 1);
        end
    endtask

    task automatic wait_drain(string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_%s: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors += 8;
        if (odv[0] !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", odv[0]); end
        if (osop[0] !== 1'b0) begin miscompares++; $display("FAIL rst_sop: got %b, required 0", osop[0]); end
        if (oeop[0] !== 1'b0) begin miscompares++; $display("FAIL rst_eop: got %b, required 0", oeop[0]); end
        if (d0 !== 24'h0) begin miscompares++; $display("FAIL rst_data: got %h, required 0", d0); end
        if (rdy[0] !== 1'b0) begin miscompares++; $display("FAIL rst_din_ready: got %b, required 0", rdy[0]); end
        if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", busy[0]); end
        if (odv[1] !== 1'b0) begin miscompares++; $display("FAIL rst_valid_s1: got %b, required 0", odv[1]); end
        if (odv[2] !== 1'b0) begin miscompares++; $display("FAIL rst_valid_as: got %b, required 0", odv[2]); end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_ctrl_s3;
        pulse_ctrl(0, 16'h0780, 16'h0438, 4'h3);
        push(24'h00000F, 1'b1, 1'b0);
        push(24'h080700, 1'b0, 1'b0);
        push(24'h040000, 1'b0, 1'b0);
        push(24'h030803, 1'b0, 1'b1);
        send_frame(0, 4, 1'b0);
        wait_drain("t1");
        vectors++;
        if (busy[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ctrl_busy_clear: got %b, required 0", busy[0]);
        end
    endtask

    task automatic test_ctrl_s1;
        logic [3:0] s1 [9];
        s1 = '{4'h0, 4'h7, 4'h8, 4'h0, 4'h0, 4'h4, 4'h3, 4'h8, 4'h3};
        pulse_ctrl(1, 16'h0780, 16'h0438, 4'h3);
        push(24'h00000F, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++)
            push({20'h0, s1[i]}, 1'b0, i == 8);
        send_frame(1, 2, 1'b0);
        wait_drain("t2");
    endtask

    task automatic test_backpressure;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(0, 16, 1'b1);
                wait_drain("t3");
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    dout_ready = ~dout_ready;
                end
            end
        join
        dout_ready = 1'b1;
    endtask

    task automatic test_midframe_send;
        logic [23:0] d;
        push(24'h0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d = 24'($urandom);
            push(d, 1'b0, i == 7);
            if (i == 4) pulse_ctrl(0, 16'h0140, 16'h00F0, 4'h0);
            drive_pixel(0, d, i == 7);
        end
        wait_drain("t4a");
        push_ctrl(16'h0140, 16'h00F0, 4'h0, 3);
        send_frame(0, 4, 1'b0);
        wait_drain("t4b");
    endtask

    task automatic test_always_send;
        for (int f = 0; f < 2; f++) begin
            push_ctrl(16'h0, 16'h0, 4'h0, 3);
            send_frame(2, 5, 1'b1);
        end
        wait_drain("t5");
    endtask

    task automatic test_reset_mid_packet;
        int x0;
        int t;
        pulse_ctrl(0, 16'h0780, 16'h0438, 4'h3);
        push_ctrl(16'h0780, 16'h0438, 4'h3, 3);
        x0 = xfers;
        din_data = 24'h123456;
        din_eop  = 1'b0;
        vin[0]   = 1'b1;
        t = 0;
        while (xfers < x0 + 1 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        csend[0] = 1'b1;
        @(posedge clk);
        #1;
        csend[0] = 1'b0;
        t = 0;
        while (xfers < x0 + 2 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        vectors++;
        if (xfers < x0 + 2) begin
            miscompares++;
            $display("FAIL t6_reach_beat1: got %0d beats, required 2", xfers - x0);
        end
        rst    = 1'b1;
        vin[0] = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        vectors += 2;
        if (odv[0] !== 1'b0) begin miscompares++; $display("FAIL t6_valid: got %b, required 0", odv[0]); end
        if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL t6_busy: got %b, required 0", busy[0]); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_frame(0, 3, 1'b0);
        wait_drain("t6");
    endtask

    initial begin
        rst        = 1'b1;
        vin        = '0;
        csend      = '0;
        din_data   = '0;
        din_eop    = 1'b0;
        dout_ready = 1'b1;
        width      = '0;
        height     = '0;
        interlaced = '0;
        done       = 1'b0;
        test_reset();
        test_ctrl_s3();
        test_ctrl_s1();
        test_backpressure();
        test_midframe_send();
        test_always_send();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
